// File: rtl/hilo_unit.sv
// HI/LO registers and RUN/IDLE sequencing for the multi-cycle multiply/divide path.
// Optional macro HILO_BYPASS_EN: forward mt_data / md results onto hi/lo and release busy in the commit cycle.
package hilo_unit_pkg;
  typedef logic [4:0] ctrl_alu_op_t;
  localparam ctrl_alu_op_t ALU_OP_MULT  = 5'd16;
  localparam ctrl_alu_op_t ALU_OP_MULTU = 5'd17;
  localparam ctrl_alu_op_t ALU_OP_DIV   = 5'd18;
  localparam ctrl_alu_op_t ALU_OP_DIVU  = 5'd19;
endpackage

module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned DIV_LAT  = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic        flush,
  input  logic        mt_hi_en,
  input  logic        mt_lo_en,
  input  logic [31:0] mt_data,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic [4:0]  md_op,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;
  logic               op_ok;
  logic               op_div;
  logic               accept;

  always_comb begin
    op_ok  = req_op inside {ALU_OP_MULT, ALU_OP_MULTU, ALU_OP_DIV, ALU_OP_DIVU};
    op_div = req_op inside {ALU_OP_DIV, ALU_OP_DIVU};
    accept = (state == IDLE) && req_valid && op_ok && !flush;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      md_a  <= '0;
      md_b  <= '0;
      md_op <= ALU_OP_MULTU;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // mt writes land even when an op is accepted; its commit overwrites later
          if (mt_hi_en) hi_q <= mt_data;
          if (mt_lo_en) lo_q <= mt_data;
          if (accept) begin
            md_a  <= req_a;
            md_b  <= req_b;
            md_op <= req_op;
            cnt   <= op_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
            state <= RUN;
          end
        end
        RUN: begin
          if (flush) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            hi_q  <= md_hi;
            lo_q  <= md_lo;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    req_ready = (state == IDLE);
    hi        = hi_q;
    lo        = lo_q;
`ifdef HILO_BYPASS_EN
    busy = (state == RUN) && (cnt != '0);
    if (state == IDLE) begin
      if (mt_hi_en) hi = mt_data;
      if (mt_lo_en) lo = mt_data;
    end else if (cnt == '0) begin
      hi = md_hi;
      lo = md_lo;
    end
`else
    busy = (state == RUN);
`endif
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: directed cases plus randomized ops, flushes and mt writes.
module tb_hilo_unit;
  import hilo_unit_pkg::*;

  localparam int unsigned MULT_LAT = 4;
  localparam int unsigned DIV_LAT  = 32;
`ifdef HILO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic [4:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        req_ready;
  logic        flush;
  logic        mt_hi_en, mt_lo_en;
  logic [31:0] mt_data;
  logic [31:0] md_a, md_b;
  logic [4:0]  md_op;
  logic [31:0] md_hi, md_lo;
  logic [31:0] hi, lo;
  logic        busy;

  hilo_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .flush(flush),
    .mt_hi_en(mt_hi_en), .mt_lo_en(mt_lo_en), .mt_data(mt_data),
    .md_a(md_a), .md_b(md_b), .md_op(md_op), .md_hi(md_hi), .md_lo(md_lo),
    .hi(hi), .lo(lo), .busy(busy)
  );

  always #5 clk = ~clk;

  // Architectural result {HI, LO}; division by zero is defined here as {a, all-ones}.
  function automatic logic [63:0] muldiv_ref(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    longint p;
    int     sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      ALU_OP_MULT: begin
        p = longint'(sa) * longint'(sb);
        return p;
      end
      ALU_OP_MULTU: return {32'd0, a} * {32'd0, b};
      ALU_OP_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      ALU_OP_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return '0;
    endcase
  endfunction

  // External combinational multiply/divide unit
  always_comb {md_hi, md_lo} = muldiv_ref(md_op, md_a, md_b);

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned cycles;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  int unsigned run_len = 0;
  logic        prev_busy = 1'b0;
  exp_t        mon_e;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a falling busy marks the end of a transaction.
  initial begin
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        run_len++;
      end else if (prev_busy) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: busy fell with no pending transaction");
        end else begin
          mon_e = sb_q.pop_front();
          check("sb_hi", hi, mon_e.hi);
          check("sb_lo", lo, mon_e.lo);
          check("sb_busy_len", run_len, mon_e.cycles);
          check("sb_ready", {31'd0, req_ready}, 32'd1);
        end
        run_len = 0;
      end
      prev_busy = (busy === 1'b1);
    end
  end

  task automatic wait_idle(int unsigned budget);
    int unsigned t = 0;
    while (req_ready !== 1'b1 && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: req_ready=%b after %0d cycles, required 1", req_ready, t);
    end
  endtask

  task automatic mt_write(logic h, logic l, logic [31:0] d);
    mt_hi_en = h; mt_lo_en = l; mt_data = d;
    @(negedge clk);
    mt_hi_en = 1'b0; mt_lo_en = 1'b0;
    if (h) m_hi = d;
    if (l) m_lo = d;
    check("mt_hi", hi, m_hi);
    check("mt_lo", lo, m_lo);
  endtask

  // Issue one op from IDLE at a negedge; flush_at = RUN cycle carrying flush (0 = none).
  task automatic run_op(logic [4:0] op, logic [31:0] a, logic [31:0] b, int unsigned flush_at,
                        logic mt_h, logic mt_l, logic [31:0] mtd, logic mt_in_run);
    int unsigned lat;
    logic [63:0] r;
    exp_t        e;
    lat = (op == ALU_OP_DIV || op == ALU_OP_DIVU) ? DIV_LAT : MULT_LAT;
    if (mt_h) m_hi = mtd;
    if (mt_l) m_lo = mtd;
    r = muldiv_ref(op, a, b);
    if (flush_at == 0) begin
      m_hi = r[63:32];
      m_lo = r[31:0];
      e.cycles = BYP ? lat - 1 : lat;
    end else begin
      e.cycles = flush_at;
    end
    e.hi = m_hi;
    e.lo = m_lo;
    sb_q.push_back(e);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    mt_hi_en = mt_h; mt_lo_en = mt_l; mt_data = mtd;
    @(negedge clk);
    req_valid = 1'b0; req_op = 5'd0;
    for (int unsigned c = 1; c <= lat; c++) begin
      mt_hi_en = mt_in_run && (c == 1);
      mt_lo_en = mt_in_run && (c == 1);
      if (mt_in_run && c == 1) mt_data = $urandom;
      flush = (c == flush_at);
      @(negedge clk);
      if (c == flush_at) break;
    end
    flush = 1'b0; mt_hi_en = 1'b0; mt_lo_en = 1'b0;
    wait_idle(8);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0]  ops [4];
    logic [4:0]  op;
    logic [31:0] a, b;
    int unsigned fl, lat;
    ops[0] = ALU_OP_MULT; ops[1] = ALU_OP_MULTU; ops[2] = ALU_OP_DIV; ops[3] = ALU_OP_DIVU;
    resetn = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    flush = 1'b0; mt_hi_en = 1'b0; mt_lo_en = 1'b0; mt_data = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_md_a", md_a, 32'd0);
    check("rst_md_op", {27'd0, md_op}, {27'd0, ALU_OP_MULTU});

    run_op(ALU_OP_MULT, 32'hFFFF_FFFF, 32'h2, 0, 0, 0, 0, 0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFE);
    run_op(ALU_OP_DIVU, 32'd100, 32'd7, 0, 0, 0, 0, 0);
    check("divu_hi", hi, 32'h2);
    check("divu_lo", lo, 32'hE);
    run_op(ALU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0, 0);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_lo", lo, 32'hFFFF_FFFD);

    mt_write(1, 0, 32'h1234);
    check("mthi_val", hi, 32'h1234);
    check("mthi_lo_kept", lo, 32'hFFFF_FFFD);
    run_op(ALU_OP_MULTU, 32'd3, 32'd5, 0, 0, 0, 0, 0);
    check("multu_hi", hi, 32'd0);
    check("multu_lo", lo, 32'hF);

    mt_write(1, 1, 32'hAAAA_AAAA);
    run_op(ALU_OP_DIVU, 32'd12345, 32'd17, 10, 0, 0, 0, 0);
    check("flush_hi", hi, 32'hAAAA_AAAA);
    check("flush_lo", lo, 32'hAAAA_AAAA);
    if (!BYP) begin
      run_op(ALU_OP_DIVU, 32'd12345, 32'd17, DIV_LAT, 0, 0, 0, 0);
      check("flush_last_hi", hi, 32'hAAAA_AAAA);
    end
    run_op(ALU_OP_MULT, 32'd6, 32'd7, 0, 1, 1, 32'h5555_0000, 0);
    check("mt_accept_lo", lo, 32'd42);

    req_valid = 1'b1; req_op = 5'd3; req_a = 32'd9; req_b = 32'd9;
    @(negedge clk);
    req_valid = 1'b0;
    check("bad_op_busy", {31'd0, busy}, 32'd0);
    check("bad_op_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = ALU_OP_MULT; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check("idle_flush_busy", {31'd0, busy}, 32'd0);
    check("idle_flush_hi", hi, m_hi);

    mt_write(1, 1, 32'h5);
    sb_q.push_back('{hi: 32'd0, lo: 32'd0, cycles: 2});
    req_valid = 1'b1; req_op = ALU_OP_MULT; req_a = 32'd11; req_b = 32'd13;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    m_hi = '0; m_lo = '0;
    check("rst_run_hi", hi, 32'd0);
    check("rst_run_lo", lo, 32'd0);
    check("rst_run_busy", {31'd0, busy}, 32'd0);
    check("rst_run_ready", {31'd0, req_ready}, 32'd1);
    repeat (MULT_LAT + 2) @(negedge clk);
    check("rst_no_commit", lo, 32'd0);

    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 3)];
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : 32'($urandom);
      lat = (op == ALU_OP_DIV || op == ALU_OP_DIVU) ? DIV_LAT : MULT_LAT;
      fl = 0;
      if ($urandom_range(0, 3) == 0) fl = $urandom_range(1, BYP ? lat - 1 : lat);
      if ($urandom_range(0, 3) == 0) begin
        run_op(op, a, b, fl, 1'($urandom), 1'($urandom), $urandom, 1'($urandom));
      end else begin
        run_op(op, a, b, fl, 0, 0, 0, 1'($urandom));
      end
    end

    repeat (4) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
